// File: rtl/seq_divider_pkg.sv
// Shared widths, state encoding and divide-by-zero result constants for the
// 8-by-4 sequential restoring divider.
package seq_divider_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int STEPS      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DIVIDEND_W-1:0] Q_DBZ     = 8'hFF;
    localparam logic [DIVISOR_W-1:0]  R_DBZ     = 4'hF;
    localparam logic [2:0]            LAST_STEP = 3'(STEPS - 1);

endpackage

// File: rtl/seq_divider_8by4_div_step.sv
// One restoring-division step: trial-subtract D from T with a ripple
// subtractor; the final borrow decides between keeping the difference or T.
module div_step
    import seq_divider_pkg::*;
(
    input  logic [DIVISOR_W:0]   t,
    input  logic [DIVISOR_W-1:0] d,
    output logic [DIVISOR_W-1:0] r_next,
    output logic                 qbit
);

    logic [DIVISOR_W:0]   d_ext;
    logic [DIVISOR_W-1:0] diff;
    logic [DIVISOR_W+1:0] borrow;

    assign d_ext     = {1'b0, d};
    assign borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi <= DIVISOR_W; gi++) begin : g_sub
            assign borrow[gi+1] = (~t[gi] & d_ext[gi]) |
                                  (~(t[gi] ^ d_ext[gi]) & borrow[gi]);
            // The top difference bit is always zero when no borrow occurs,
            // because the remainder stays below D.
            if (gi < DIVISOR_W) begin : g_diff
                assign diff[gi] = t[gi] ^ d_ext[gi] ^ borrow[gi];
            end
        end
    endgenerate

    assign qbit   = ~borrow[DIVISOR_W+1];
    assign r_next = qbit ? diff : t[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_divider_8by4.sv
// Sequential 8-bit by 4-bit restoring divider: one quotient bit per clock,
// start/done handshake, results held until the next operation completes.
module seq_divider_8by4
    import seq_divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
);

    state_t                state_q, state_d;
    logic [DIVISOR_W-1:0]  r_q, r_d;
    logic [DIVIDEND_W-1:0] q_q, q_d;
    logic [DIVISOR_W-1:0]  d_q, d_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W-1:0]  step_r;
    logic                  step_qbit;

    div_step u_step (
        .t      ({r_q, q_q[DIVIDEND_W-1]}),
        .d      (d_q),
        .r_next (step_r),
        .qbit   (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        r_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end else begin
                        // Skip the iterations entirely and report the error result.
                        quot_d  = Q_DBZ;
                        rem_d   = R_DBZ;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                r_d   = step_r;
                q_d   = {q_q[DIVIDEND_W-2:0], step_qbit};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_STEP) begin
                    quot_d  = {q_q[DIVIDEND_W-2:0], step_qbit};
                    rem_d   = step_r;
                    dbz_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;

endmodule
